// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared state encoding, default timing constants and GRB word type
package ws2812_pkg;

    typedef enum logic [2:0] {ST_IDLE, ST_HIGH, ST_LOW, ST_WAIT, ST_LATCH} state_t;

    typedef logic [23:0] grb_t;

    localparam int DEF_T0H          = 20;
    localparam int DEF_T0L          = 42;
    localparam int DEF_T1H          = 40;
    localparam int DEF_T1L          = 22;
    localparam int DEF_RESET_CYCLES = 2500;
    localparam int DEF_LED_COUNT    = 100;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/ws2812_bit_timer.sv
// ws2812_bit_timer: times one high/low pulse pair for the bit value presented on i_bit
module ws2812_bit_timer
    import ws2812_pkg::*;
#(
    parameter int T0H = DEF_T0H,
    parameter int T0L = DEF_T0L,
    parameter int T1H = DEF_T1H,
    parameter int T1L = DEF_T1L
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start,
    input  logic i_bit,
    output logic o_dout_phase,
    output logic o_bit_done
);

    localparam int CW = $clog2(max4(T0H, T0L, T1H, T1L) + 1);

    logic          r_run;
    logic          r_hi;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_th;
    logic [CW-1:0] w_tl;

    // i_bit stays stable for the whole bit, so phase lengths are picked live from it
    assign w_th         = i_bit ? CW'(T1H - 1) : CW'(T0H - 1);
    assign w_tl         = i_bit ? CW'(T1L - 1) : CW'(T0L - 1);
    assign o_dout_phase = r_run & r_hi;
    assign o_bit_done   = r_run & ~r_hi & (r_cnt == w_tl);

    // High phase then low phase; a start on the done cycle chains the next bit gaplessly
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_run <= 1'b0;
            r_hi  <= 1'b0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_run <= 1'b1;
            r_hi  <= 1'b1;
            r_cnt <= '0;
        end else if (o_bit_done) begin
            r_run <= 1'b0;
            r_cnt <= '0;
        end else if (r_run && r_hi && r_cnt == w_th) begin
            r_hi  <= 1'b0;
            r_cnt <= '0;
        end else if (r_run) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/ws2812_serializer.sv
// ws2812_serializer: streams buffered 24-bit GRB words onto the WS2812 data line
module ws2812_serializer
    import ws2812_pkg::*;
#(
    parameter int T0H          = DEF_T0H,
    parameter int T0L          = DEF_T0L,
    parameter int T1H          = DEF_T1H,
    parameter int T1L          = DEF_T1L,
    parameter int RESET_CYCLES = DEF_RESET_CYCLES,
    parameter int LED_COUNT    = DEF_LED_COUNT
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [23:0] i_grb_data,
    input  logic        i_grb_valid,
    output logic        o_data_req,
    output logic        o_dout,
    output logic        o_busy,
    output logic        o_frame_done,
    output logic        o_overflow
);

    localparam int WCW = $clog2(LED_COUNT + 1);
    localparam int LCW = $clog2(RESET_CYCLES + 1);

    state_t         r_state;
    grb_t           r_hold;
    grb_t           r_shift;
    logic           r_hold_valid;
    logic           r_valid_q;
    logic           r_first;
    logic           r_req;
    logic           r_dout;
    logic           r_done;
    logic           r_ovf;
    logic [4:0]     r_idx;
    logic [WCW-1:0] r_words;
    logic [LCW-1:0] r_lat;
    logic           w_capture;
    logic           w_bit_end;
    logic           w_full;
    logic           w_load;
    logic           w_shift;
    logic           w_start;
    logic           w_phase;
    logic           w_bit_done;

    assign w_capture = i_grb_valid & ~r_valid_q;
    assign w_bit_end = (r_state == ST_HIGH || r_state == ST_LOW) && w_bit_done;
    assign w_full    = r_words == WCW'(LED_COUNT);
    assign w_load    = r_hold_valid && (r_state == ST_IDLE || r_state == ST_WAIT ||
                       (w_bit_end && r_idx == 5'd0 && !w_full));
    assign w_shift   = w_bit_end && r_idx != 5'd0;
    assign w_start   = w_load | w_shift;

    assign o_data_req   = r_req;
    assign o_dout       = r_dout;
    assign o_busy       = r_state != ST_IDLE;
    assign o_frame_done = r_done;
    assign o_overflow   = r_ovf;

    ws2812_bit_timer #(
        .T0H(T0H),
        .T0L(T0L),
        .T1H(T1H),
        .T1L(T1L)
    ) u_timer (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (w_start),
        .i_bit       (r_shift[23]),
        .o_dout_phase(w_phase),
        .o_bit_done  (w_bit_done)
    );

    // Edge-detected capture into the one-word hold buffer; a load in the same cycle frees the slot
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid_q    <= 1'b0;
            r_hold_valid <= 1'b0;
            r_hold       <= '0;
            r_ovf        <= 1'b0;
        end else begin
            r_valid_q <= i_grb_valid;
            r_ovf     <= w_capture && r_hold_valid && !w_load;
            if (w_capture && (!r_hold_valid || w_load)) begin
                r_hold       <= i_grb_data;
                r_hold_valid <= 1'b1;
            end else if (w_load) begin
                r_hold_valid <= 1'b0;
            end
        end
    end

    // Frame FSM: word loads, bit shifting, word count, latch interval and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_idx   <= '0;
            r_words <= '0;
            r_lat   <= '0;
            r_done  <= 1'b0;
            r_req   <= 1'b0;
            r_first <= 1'b1;
            r_dout  <= 1'b0;
        end else begin
            r_dout  <= w_phase;
            r_first <= 1'b0;
            r_req   <= r_first || r_done || (w_load && int'(r_words) + 1 < LED_COUNT);
            r_done  <= 1'b0;
            if (w_load) begin
                r_shift <= r_hold;
                r_idx   <= 5'd23;
                r_words <= r_words + WCW'(1);
            end else if (w_shift) begin
                r_shift <= {r_shift[22:0], 1'b0};
                r_idx   <= r_idx - 5'd1;
            end
            case (r_state)
                ST_LATCH: begin
                    r_done <= r_lat == LCW'(RESET_CYCLES - 2);
                    if (r_lat == LCW'(RESET_CYCLES - 1)) begin
                        r_state <= ST_IDLE;
                        r_words <= '0;
                        r_lat   <= '0;
                    end else begin
                        r_lat <= r_lat + LCW'(1);
                    end
                end
                default: begin
                    if (w_start) r_state <= ST_HIGH;
                    else if (w_bit_end) r_state <= w_full ? ST_LATCH : ST_WAIT;
                    else if (r_state == ST_HIGH && !w_phase) r_state <= ST_LOW;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_serializer.sv
// tb_ws2812_serializer: directed vectors plus corner sequences, decoding the data line back to bits
module tb_ws2812_serializer;

    logic        clk;
    logic        rst;
    logic [23:0] data;
    logic        valid;
    logic        data_req;
    logic        dout;
    logic        busy;
    logic        frame_done;
    logic        overflow;

    int n_checks = 0;
    int n_err    = 0;

    // line decoder state, owned by the monitor process only
    logic q[$];
    int   cyc = 0;
    int   hi, lo, starts, bad, hi_total, req_cnt, ovf_cnt, fd_cnt, fd_cyc, req_cyc, fall_cyc;
    logic last_one;

    typedef struct {
        logic [23:0] word;
        int          slen;
        int          hi_total;
    } vec_t;

    vec_t vecs[6];

    ws2812_serializer #(
        .T0H(2),
        .T0L(4),
        .T1H(4),
        .T1L(2),
        .RESET_CYCLES(10),
        .LED_COUNT(2)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_grb_data  (data),
        .i_grb_valid (valid),
        .o_data_req  (data_req),
        .o_dout      (dout),
        .o_busy      (busy),
        .o_frame_done(frame_done),
        .o_overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Decode pulse pairs: 4-high is a 1, 2-high is a 0; low runs inside a word must match the bit
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            q.delete();
            hi = 0; lo = 100; starts = 0; bad = 0; hi_total = 0;
            req_cnt = 0; ovf_cnt = 0; fd_cnt = 0; fd_cyc = 0; req_cyc = 0; fall_cyc = 0;
            last_one = 1'b0;
        end else begin
            if (data_req) begin req_cnt++; req_cyc = cyc; end
            if (overflow) ovf_cnt++;
            if (frame_done) begin fd_cnt++; fd_cyc = cyc; end
            if (dout) begin
                if (hi == 0) begin
                    if (lo >= 8) starts++;
                    else if (lo != (last_one ? 2 : 4)) bad++;
                end
                hi++;
                hi_total++;
            end else begin
                if (hi != 0) begin
                    if (hi == 4) q.push_back(1'b1);
                    else if (hi == 2) q.push_back(1'b0);
                    else bad++;
                    last_one = (hi == 4);
                    hi = 0;
                    lo = 0;
                    fall_cyc = cyc;
                end
                lo++;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [23:0] qword(input int base);
        logic [23:0] w = '0;
        for (int i = 0; i < 24; i++) w = {w[22:0], (base + i < q.size()) ? q[base + i] : 1'b0};
        return w;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic strobe(input logic [23:0] w, input int len);
        @(posedge clk);
        #1 data = w;
        valid = 1'b1;
        repeat (len) @(posedge clk);
        #1 valid = 1'b0;
    endtask

    // one-cycle strobe; capture edge N, dout must be low after N and N+1, high after N+2
    task automatic strobe_lat(input logic [23:0] w, input string nm);
        @(posedge clk);
        #1 data = w;
        valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        @(negedge clk) chk({nm, "_lat_n0"}, dout, 1'b0);
        @(negedge clk) chk({nm, "_lat_n1"}, dout, 1'b0);
        @(negedge clk) chk({nm, "_lat_n2"}, dout, 1'b1);
    endtask

    task automatic wait_quiet(input int nbits, input int budget);
        int k = 0;
        while (!(q.size() >= nbits && lo >= 20) && k < budget) begin
            @(posedge clk);
            #1 k++;
        end
        if (k >= budget) begin
            n_checks++;
            n_err++;
            $display("FAIL wait_quiet: got %0d bits expected %0d", q.size(), nbits);
        end
    endtask

    task automatic wait_fd(input int budget);
        int k = 0;
        while (fd_cnt == 0 && k < budget) begin
            @(posedge clk);
            #1 k++;
        end
        if (k >= budget) begin
            n_checks++;
            n_err++;
            $display("FAIL wait_fd: got no frame_done expected one");
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{24'hFF0000, 2, 64};
        vecs[1] = '{24'h000001, 1, 50};
        vecs[2] = '{24'hA5A5A5, 3, 72};
        vecs[3] = '{24'h800001, 20, 52};
        vecs[4] = '{24'hFFFFFF, 1, 96};
        vecs[5] = '{24'h000000, 1, 48};
        rst = 1'b1;
        valid = 1'b0;
        data = '0;

        // reset values and the post-reset request pulse
        repeat (3) @(posedge clk);
        @(negedge clk) chk("rst_outputs", {dout, data_req, busy, frame_done, overflow}, 5'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk) chk("rst_req_hi", data_req, 1'b1);
        @(negedge clk) chk("rst_req_lo", data_req, 1'b0);

        // single words: one per frame start, ending in WAIT
        for (int i = 0; i < 6; i++) begin
            do_reset();
            strobe(vecs[i].word, vecs[i].slen);
            wait_quiet(24, 600);
            chk("tbl_word", qword(0), vecs[i].word);
            chk("tbl_nbits", q.size(), 24);
            chk("tbl_hi_total", hi_total, vecs[i].hi_total);
            chk("tbl_bad_runs", bad, 0);
            chk("tbl_starts", starts, 1);
            chk("tbl_req_cnt", req_cnt, 2);
            chk("tbl_busy_wait", busy, 1'b1);
            chk("tbl_ovf", ovf_cnt, 0);
            chk("tbl_fd", fd_cnt, 0);
        end

        // back-to-back words, latch interval, frame_done then data_req
        do_reset();
        strobe(24'hA5A5A5, 1);
        strobe(24'h000001, 1);
        wait_fd(1000);
        chk("b2b_w0", qword(0), 24'hA5A5A5);
        chk("b2b_w1", qword(24), 24'h000001);
        chk("b2b_nbits", q.size(), 48);
        chk("b2b_starts", starts, 1);
        chk("b2b_bad_runs", bad, 0);
        chk("b2b_fd_cnt", fd_cnt, 1);
        chk("b2b_fd_delay", fd_cyc - fall_cyc, 10);
        chk("b2b_req_after_fd", req_cyc - fd_cyc, 1);
        chk("b2b_req_cnt", req_cnt, 3);
        chk("b2b_busy", busy, 1'b0);

        // three strobes during one word: third dropped with overflow
        do_reset();
        strobe_lat(24'h123456, "ovf");
        repeat (5) @(posedge clk);
        strobe(24'hC3C3C3, 1);
        strobe(24'hFFFFFF, 1);
        repeat (3) @(posedge clk);
        #1 chk("ovf_cnt", ovf_cnt, 1);
        wait_fd(1000);
        chk("ovf_w0", qword(0), 24'h123456);
        chk("ovf_w1", qword(24), 24'hC3C3C3);
        chk("ovf_nbits", q.size(), 48);
        chk("ovf_fd_cnt", fd_cnt, 1);

        // late second word: line stays low in WAIT, then restarts with idle latency
        do_reset();
        strobe(24'h0F0F0F, 1);
        wait_quiet(24, 600);
        repeat (40) @(posedge clk);
        #1 chk("late_busy", busy, 1'b1);
        chk("late_nbits_wait", q.size(), 24);
        chk("late_lo_run", lo >= 50, 1'b1);
        strobe_lat(24'hF00F01, "late");
        wait_fd(1000);
        chk("late_w0", qword(0), 24'h0F0F0F);
        chk("late_w1", qword(24), 24'hF00F01);
        chk("late_starts", starts, 2);
        chk("late_bad_runs", bad, 0);
        chk("late_fd_cnt", fd_cnt, 1);

        // reset in the middle of a high pulse with a word pending
        do_reset();
        strobe(24'hFFFFFF, 1);
        strobe(24'hFFFFFF, 1);
        begin
            int k = 0;
            while (!(q.size() >= 3 && dout) && k < 200) begin
                @(posedge clk);
                #1 k++;
            end
            chk("mid_reached", q.size() >= 3 && dout, 1'b1);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk) chk("mid_rst_outputs", {dout, data_req, busy, frame_done, overflow}, 5'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk) chk("mid_req_hi", data_req, 1'b1);
        repeat (60) @(posedge clk);
        #1 chk("mid_discarded", q.size(), 0);
        chk("mid_idle", busy, 1'b0);
        strobe(24'h00FF00, 1);
        strobe(24'h0000FF, 1);
        wait_fd(1000);
        chk("mid_w0", qword(0), 24'h00FF00);
        chk("mid_w1", qword(24), 24'h0000FF);
        chk("mid_nbits", q.size(), 48);
        chk("mid_fd_cnt", fd_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
